// File: rtl/maint_sched.sv
// Maintenance scheduler: arbitrates refresh / ZQ / periodic-read requests and emits their instruction sequences.
// Latency: request seen in IDLE -> ARB -> DRAIN -> first instruction on the 3rd cycle when the dispatcher is idle.
// Backpressure: each instruction is held stable on maint_instr until maint_ack; one instruction per cycle at full rate.
module maint_sched #(
   parameter int         TRP     = 6,
   parameter int         TZQCS   = 64,
   parameter int         TRDWAIT = 32,
   parameter logic [3:0] OP_PREA = 4'h1,
   parameter logic [3:0] OP_REF  = 4'h2,
   parameter logic [3:0] OP_ZQ   = 4'h3,
   parameter logic [3:0] OP_RD   = 4'h4,
   parameter logic [3:0] OP_WAIT = 4'h5,
   parameter logic [3:0] OP_END  = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        autoref_req,
   input  logic        zq_req,
   input  logic        pr_rd_req,
   input  logic [27:0] trfc,
   input  logic        dispatcher_busy,
   input  logic        rdback_fifo_empty,
   output logic        maint_en,
   output logic [31:0] maint_instr,
   input  logic        maint_ack,
   output logic        autoref_ack,
   output logic        zq_ack,
   output logic        pr_rd_ack,
   output logic        periodic_read_lock,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_ARB, S_DRAIN, S_ISSUE, S_DONE} state_t;
   typedef enum logic [1:0] {G_NONE, G_AR, G_ZQ, G_RD} grant_t;

   state_t      state, state_nxt;
   grant_t      grant, grant_nxt, arb_sel;
   logic [2:0]  idx, idx_nxt;
   logic [27:0] trfc_q, trfc_nxt;
   logic [31:0] cur;

   // Fixed-priority pick among the requests asserted right now
   always_comb begin
      if (autoref_req)    arb_sel = G_AR;
      else if (zq_req)    arb_sel = G_ZQ;
      else if (pr_rd_req) arb_sel = G_RD;
      else                arb_sel = G_NONE;
   end

   // Sequence entry addressed by the latched grant and index
   always_comb begin
      cur = {OP_END, 28'd0};
      case (grant)
         G_AR: begin
            case (idx)
               3'd0:    cur = {OP_PREA, 28'd0};
               3'd1:    cur = {OP_WAIT, 28'(TRP)};
               3'd2:    cur = {OP_REF,  28'd0};
               3'd3:    cur = {OP_WAIT, trfc_q};
               default: cur = {OP_END,  28'd0};
            endcase
         end
         G_ZQ: begin
            case (idx)
               3'd0:    cur = {OP_PREA, 28'd0};
               3'd1:    cur = {OP_WAIT, 28'(TRP)};
               3'd2:    cur = {OP_ZQ,   28'd0};
               3'd3:    cur = {OP_WAIT, 28'(TZQCS)};
               default: cur = {OP_END,  28'd0};
            endcase
         end
         G_RD: begin
            case (idx)
               3'd0:    cur = {OP_RD,   28'd0};
               3'd1:    cur = {OP_WAIT, 28'(TRDWAIT)};
               default: cur = {OP_END,  28'd0};
            endcase
         end
         default: cur = {OP_END, 28'd0};
      endcase
   end

   // Next-state and output decode; outputs depend only on registered state so reset clears them next cycle
   always_comb begin
      state_nxt          = state;
      grant_nxt          = grant;
      idx_nxt            = idx;
      trfc_nxt           = trfc_q;
      maint_en           = 1'b0;
      maint_instr        = 32'd0;
      autoref_ack        = 1'b0;
      zq_ack             = 1'b0;
      pr_rd_ack          = 1'b0;
      periodic_read_lock = 1'b0;
      busy               = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (autoref_req || zq_req || pr_rd_req) state_nxt = S_ARB;
         end
         S_ARB: begin
            // A request that dropped before this cycle gets no grant
            grant_nxt          = arb_sel;
            idx_nxt            = 3'd0;
            periodic_read_lock = (arb_sel == G_RD);
            if (arb_sel == G_AR) trfc_nxt = trfc;
            state_nxt = (arb_sel == G_NONE) ? S_IDLE : S_DRAIN;
         end
         S_DRAIN: begin
            periodic_read_lock = (grant == G_RD);
            if (!dispatcher_busy && rdback_fifo_empty) begin
               state_nxt = S_ISSUE;
               idx_nxt   = 3'd0;
            end
         end
         S_ISSUE: begin
            maint_en           = 1'b1;
            maint_instr        = cur;
            periodic_read_lock = (grant == G_RD);
            if (maint_ack) begin
               if (cur[31:28] == OP_END) begin
                  state_nxt = S_DONE;
                  idx_nxt   = 3'd0;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end
         end
         S_DONE: begin
            periodic_read_lock = (grant == G_RD);
            autoref_ack        = (grant == G_AR);
            zq_ack             = (grant == G_ZQ);
            pr_rd_ack          = (grant == G_RD);
            state_nxt          = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, grant, index and latched refresh time; reset abandons any sequence without an ack
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         grant  <= G_NONE;
         idx    <= 3'd0;
         trfc_q <= 28'd0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         idx    <= idx_nxt;
         trfc_q <= trfc_nxt;
      end
   end

endmodule

// File: tb/tb_maint_sched.sv
// Bench for maint_sched: scoreboard of expected instructions and ack pulses.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The receiver acks every cycle except when a stall is armed.
module tb_maint_sched;

   localparam logic [31:0] TOK = 32'hACC0_0000;

   typedef struct packed {
      logic [31:0] dat;
      logic        lock;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        autoref_req = 1'b0;
   logic        zq_req = 1'b0;
   logic        pr_rd_req = 1'b0;
   logic [27:0] trfc = 28'd110;
   logic        dispatcher_busy = 1'b0;
   logic        rdback_fifo_empty = 1'b1;
   logic        maint_ack = 1'b1;
   logic        maint_en;
   logic [31:0] maint_instr;
   logic        autoref_ack, zq_ack, pr_rd_ack, periodic_read_lock, busy;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          req_cyc = 0;
   int          first_xfer = -1;
   int          last_xfer = -1;
   int          stall_left = 0;
   logic [31:0] stall_instr = 32'd0;
   logic        abort_arm = 1'b0;
   logic        trfc_poke = 1'b0;
   logic        zq_drop = 1'b0;
   int          disp_left = 0;
   int          fifo_left = 0;

   maint_sched dut (
      .clk(clk), .rst(rst),
      .autoref_req(autoref_req), .zq_req(zq_req), .pr_rd_req(pr_rd_req),
      .trfc(trfc), .dispatcher_busy(dispatcher_busy), .rdback_fifo_empty(rdback_fifo_empty),
      .maint_en(maint_en), .maint_instr(maint_instr), .maint_ack(maint_ack),
      .autoref_ack(autoref_ack), .zq_ack(zq_ack), .pr_rd_ack(pr_rd_ack),
      .periodic_read_lock(periodic_read_lock), .busy(busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] dat, input logic lock);
      exp_t e;
      e.dat  = dat;
      e.lock = lock;
      sb.push_back(e);
   endtask

   task automatic push_ar(input logic [27:0] t);
      push(32'h1000_0000, 1'b0);
      push(32'h5000_0006, 1'b0);
      push(32'h2000_0000, 1'b0);
      push({4'h5, t},     1'b0);
      push(32'hF000_0000, 1'b0);
      push(TOK | 32'd4,   1'b0);
   endtask

   task automatic push_zq();
      push(32'h1000_0000, 1'b0);
      push(32'h5000_0006, 1'b0);
      push(32'h3000_0000, 1'b0);
      push(32'h5000_0040, 1'b0);
      push(32'hF000_0000, 1'b0);
      push(TOK | 32'd2,   1'b0);
   endtask

   task automatic push_rd();
      push(32'h4000_0000, 1'b1);
      push(32'h5000_0020, 1'b1);
      push(32'hF000_0000, 1'b1);
      push(TOK | 32'd1,   1'b1);
   endtask

   task automatic sb_pop(input string tag, input logic [31:0] got, input logic lock);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_unexpected"}, {31'b0, lock, got}, 64'hDEAD_0000_DEAD);
      end else begin
         e = sb.pop_front();
         check(tag, {31'b0, lock, got}, {31'b0, e.lock, e.dat});
      end
   endtask

   // Output monitor on the falling edge
   initial forever begin
      logic [2:0] acks;
      @(negedge clk);
      if (rst) begin
         if (maint_en && maint_ack) begin
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            sb_pop("instr", maint_instr, periodic_read_lock);
         end else if (maint_en && sb.size() > 0) begin
            check("stable", 64'(maint_instr), 64'(sb[0].dat));
         end
         acks = {autoref_ack, zq_ack, pr_rd_ack};
         if (|acks) sb_pop("ack", TOK | {29'b0, acks}, periodic_read_lock);
         if (dispatcher_busy || !rdback_fifo_empty) check("drain_en", 64'(maint_en), 64'd0);
      end
   end

   // Drive handshakes cycle by cycle until the scoreboard empties and the DUT is idle
   task automatic run(input string tag, input int budget);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         @(posedge clk);
         #1;
         n++;
         if (!rst) begin
            check({tag, "_rst_out"},
                  {26'b0, maint_en, maint_instr, autoref_ack, zq_ack, pr_rd_ack, periodic_read_lock, busy},
                  64'd0);
            rst = 1'b1;
         end
         if (autoref_ack) autoref_req = 1'b0;
         if (zq_ack)      zq_req = 1'b0;
         if (pr_rd_ack)   pr_rd_req = 1'b0;
         if (stall_left > 0 && maint_en && maint_instr == stall_instr) begin
            maint_ack = 1'b0;
            stall_left--;
         end else begin
            maint_ack = 1'b1;
         end
         if (abort_arm && maint_en && maint_instr == 32'h2000_0000) begin
            rst = 1'b0;
            abort_arm = 1'b0;
         end
         if (trfc_poke && maint_en) trfc = 28'hABC_DEF0;
         if (zq_drop && maint_en) zq_req = 1'b0;
         if (disp_left > 0) disp_left--;
         dispatcher_busy = (disp_left > 0);
         if (fifo_left > 0) fifo_left--;
         rdback_fifo_empty = (fifo_left == 0);
         done = (sb.size() == 0) && !busy && rst && !autoref_req && !zq_req && !pr_rd_req;
      end
      check({tag, "_done"}, 64'(done), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset",
            {26'b0, maint_en, maint_instr, autoref_ack, zq_ack, pr_rd_ack, periodic_read_lock, busy},
            64'd0);
      rst = 1'b1;

      // Auto-refresh at full rate; trfc changes after the grant must not leak in
      first_xfer = -1;
      trfc = 28'd110;
      push_ar(28'd110);
      trfc_poke = 1'b1;
      autoref_req = 1'b1;
      req_cyc = cyc;
      run("ar", 60);
      trfc_poke = 1'b0;
      check("ar_latency", 64'(first_xfer - req_cyc), 64'd3);
      check("ar_rate", 64'(last_xfer - first_xfer), 64'd4);

      // ZQ and periodic read together: ZQ first, then the locked read sequence
      push_zq();
      push_rd();
      zq_req = 1'b1;
      pr_rd_req = 1'b1;
      run("zq_rd", 200);

      // Dispatcher busy then readback FIFO non-empty hold off issue
      first_xfer = -1;
      trfc = 28'd20;
      push_ar(28'd20);
      disp_left = 20;
      fifo_left = 25;
      dispatcher_busy = 1'b1;
      rdback_fifo_empty = 1'b0;
      autoref_req = 1'b1;
      req_cyc = cyc;
      run("drain", 200);
      check("drain_latency", 64'(first_xfer - req_cyc), 64'd26);

      // Receiver stalls three cycles on the second instruction
      push_ar(28'd20);
      stall_instr = 32'h5000_0006;
      stall_left = 3;
      autoref_req = 1'b1;
      run("stall", 100);
      check("stall_applied", 64'(stall_left), 64'd0);

      // Request withdrawn before arbitration: nothing issued
      pr_rd_req = 1'b1;
      @(posedge clk);
      #1;
      pr_rd_req = 1'b0;
      run("no_grant", 10);

      // Request withdrawn after the grant still completes and acks
      push_zq();
      zq_drop = 1'b1;
      zq_req = 1'b1;
      run("zq_drop", 60);
      zq_drop = 1'b0;

      // Reset at the third instruction aborts silently; held request restarts from PREA
      push(32'h1000_0000, 1'b0);
      push(32'h5000_0006, 1'b0);
      push_ar(28'd20);
      abort_arm = 1'b1;
      autoref_req = 1'b1;
      run("abort", 100);
      check("abort_applied", 64'(abort_arm), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/maint_sched.md
MAINT_SCHED -- requirements
Module: maint_sched

Interface
REQ-001 SHALL have parameter TRP, default 6, meaning wait operand in cycles placed after a precharge-all.
REQ-002 SHALL have parameter TZQCS, default 64, meaning wait operand in cycles placed after a ZQ-short.
REQ-003 SHALL have parameter TRDWAIT, default 32, meaning wait operand in cycles placed after a periodic read.
REQ-004 SHALL have parameters OP_PREA=4'h1, OP_REF=4'h2, OP_ZQ=4'h3, OP_RD=4'h4, OP_WAIT=4'h5, OP_END=4'hF, meaning the opcode values placed in maint_instr[31:28].
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1, the reset; it is synchronous and active-low.
REQ-007 SHALL have port autoref_req, input, 1, level auto-refresh request, held until autoref_ack.
REQ-008 SHALL have port zq_req, input, 1, level ZQ-calibration request, held until zq_ack.
REQ-009 SHALL have port pr_rd_req, input, 1, level periodic-read request, held until pr_rd_ack.
REQ-010 SHALL have port trfc, input, 28, refresh wait operand in cycles.
REQ-011 SHALL have port dispatcher_busy, input, 1, high while the instruction-sequence dispatcher executes.
REQ-012 SHALL have port rdback_fifo_empty, input, 1, high when the readback FIFO holds no data.
REQ-013 SHALL have port maint_en, output, 1, instruction valid.
REQ-014 SHALL have port maint_instr, output, 32, instruction word: [31:28] opcode, [27:0] operand.
REQ-015 SHALL have port maint_ack, input, 1, instruction-receiver acceptance.
REQ-016 SHALL have ports autoref_ack, zq_ack and pr_rd_ack, output, 1 each, single-cycle completion pulses.
REQ-017 SHALL have port periodic_read_lock, output, 1, high while a periodic-read sequence is in flight.
REQ-018 SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, ARB, DRAIN, ISSUE and DONE.
REQ-020 IDLE SHALL go to ARB on the cycle any request input is high.
REQ-021 ARB SHALL grant in fixed priority autoref > zq > pr_rd, latch the grant, latch trfc when autoref is granted, and go to DRAIN.
REQ-022 DRAIN SHALL remain until dispatcher_busy=0 and rdback_fifo_empty=1 in the same cycle, then go to ISSUE with sequence index 0.
REQ-023 The autoref sequence SHALL be {PREA,0}, {WAIT,TRP}, {REF,0}, {WAIT,latched trfc}, {END,0}.
REQ-024 The ZQ sequence SHALL be {PREA,0}, {WAIT,TRP}, {ZQ,0}, {WAIT,TZQCS}, {END,0}.
REQ-025 The periodic-read sequence SHALL be {RD,0}, {WAIT,TRDWAIT}, {END,0}.
REQ-026 Each wait operand SHALL be zero-extended to 28 bits.
REQ-027 In ISSUE, maint_en=1 and maint_instr SHALL hold the current entry stable until a cycle with maint_en&maint_ack; that cycle is the transfer.
REQ-028 On a non-END transfer, the index SHALL increment and the next entry SHALL appear the following cycle with maint_en kept at 1 (one instruction per cycle at full rate).
REQ-029 On the END transfer, maint_en SHALL deassert the next cycle and the FSM SHALL go to DONE.
REQ-030 DONE SHALL pulse the granted *_ack for exactly one cycle and then go to IDLE.
REQ-031 A request still high in IDLE after its ack SHALL be treated as a new request.
REQ-032 Requests arriving after ARB SHALL not preempt the active sequence; they are served after DONE by priority.
REQ-033 periodic_read_lock SHALL be 1 from ARB-granting pr_rd through DONE inclusive.
REQ-034 maint_ack while maint_en=0 SHALL be ignored.
REQ-035 Changes to trfc after ARB SHALL not affect the active sequence.
REQ-036 A request deasserting before its grant SHALL not be granted; a request deasserting after its grant SHALL still complete its sequence and receive its ack.

Reset
REQ-037 While rst=0 at a clock edge, the FSM SHALL go to IDLE, the index to 0, and maint_en, maint_instr, all acks, periodic_read_lock and busy SHALL be 0 on the next cycle, including when reset occurs mid-sequence; no ack is issued for an aborted sequence.

Verification
REQ-038 autoref_req=1, trfc=28'd110, dispatcher idle, maint_ack tied 1 -> after the ARB and DRAIN cycles, 5 consecutive instructions 0x1000_0000, 0x5000_0006, 0x2000_0000, 0x5000_006E, 0xF000_0000, then one autoref_ack pulse.
REQ-039 zq_req and pr_rd_req rise on the same cycle -> ZQ sequence with TZQCS=0x40 first, then the RD sequence; periodic_read_lock=1 only during the second sequence.
REQ-040 dispatcher_busy=1 for 20 cycles after the grant -> maint_en stays 0 until busy falls and rdback_fifo_empty=1.
REQ-041 maint_ack held low 3 cycles on the 2nd instruction -> 0x5000_0006 stays stable on maint_instr with maint_en=1 for those cycles, no entry skipped or repeated.
REQ-042 rst=0 applied at the 3rd instruction of an autoref sequence -> all outputs 0 next cycle, no autoref_ack; with autoref_req still 1 after release, the sequence restarts from PREA.
